// File: rtl/io_block_reg_if.sv
// io_block_reg_if: config chain and pad/connector data signals of one IO block.
// Latency: none, pure signal bundle.
// Backpressure: none; the block only qualifies its outputs with config_done.
interface io_block_reg_if #(
  parameter int WIDTH = 6
) ();

  // serial configuration chain
  logic             config_in;
  logic             config_en;
  logic             config_out;
  logic             config_done;

  // pad and connector data
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] cx_io;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] data_oe;
  logic [WIDTH-1:0] io_cx;

  // driver side: configuration source plus pads and connector
  modport master (
    output config_in, config_en, data_in, cx_io,
    input  config_out, config_done, data_out, data_oe, io_cx
  );

  // the IO block itself
  modport slave (
    input  config_in, config_en, data_in, cx_io,
    output config_out, config_done, data_out, data_oe, io_cx
  );

endinterface

// File: rtl/io_block_reg.sv
// io_block_reg: WIDTH pad cells with own serial config chain (4 bits/cell); optional IO_BLOCK_SYNC_EN input synchroniser.
// Latency: input path 0/1 cycle (2/3 with IO_BLOCK_SYNC_EN), output path 0/1 cycle; config shifts 1 bit per enabled clock.
// Backpressure: none; all outputs held at 0 until config_done and during every cycle with config_en high.
module io_block_reg #(
  parameter int WIDTH    = 6,
  parameter int CFG_BITS = 4
) (
  input  logic          config_clk,
  input  logic          sys_reset,
  io_block_reg_if.slave io
);

  localparam int            N     = WIDTH * CFG_BITS;
  localparam int            CW    = $clog2(N + 1);
  localparam logic [CW-1:0] N_CNT = CW'(N);

  // config chain, shift counter and done flag
  logic [N-1:0]     cfg_q, cfg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  // per-cell data flops for the registered paths
  logic [WIDTH-1:0] in_q, in_d;
  logic [WIDTH-1:0] out_q, out_d;

  // decoded per-cell config fields
  logic [WIDTH-1:0] in_en;
  logic [WIDTH-1:0] out_en;
  logic [WIDTH-1:0] reg_sel;
  logic [WIDTH-1:0] inv;

  // datapath intermediates
  logic [WIDTH-1:0] din_src;
  logic [WIDTH-1:0] a_vec;
  logic [WIDTH-1:0] b_vec;
  logic [WIDTH-1:0] in_path;
  logic [WIDTH-1:0] out_path;
  logic             gate;

  // ---------------------------------------------------------------------
  // Configuration chain
  // ---------------------------------------------------------------------

  // Shift one bit in per enabled clock; counter saturates so done stays up on later reconfigs
  always_comb begin
    cfg_d = cfg_q;
    cnt_d = cnt_q;
    if (io.config_en) begin
      cfg_d = {cfg_q[N-2:0], io.config_in};
      if (cnt_q != N_CNT) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    done_d = (cnt_d == N_CNT);
  end

  // Chain state registers; reset forces a full reconfiguration from bit 0
  always_ff @(posedge config_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      cfg_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign io.config_out  = cfg_q[N-1];
  assign io.config_done = done_q;

  // ---------------------------------------------------------------------
  // Field decode: cell i owns cfg[4i+3:4i] = {inv, reg, out_en, in_en}
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign in_en[i]   = cfg_q[CFG_BITS*i + 0];
    assign out_en[i]  = cfg_q[CFG_BITS*i + 1];
    assign reg_sel[i] = cfg_q[CFG_BITS*i + 2];
    assign inv[i]     = cfg_q[CFG_BITS*i + 3];
  end

  // ---------------------------------------------------------------------
  // Optional pad input synchroniser
  // ---------------------------------------------------------------------
`ifdef IO_BLOCK_SYNC_EN
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  // Two-flop synchroniser on the asynchronous pad inputs, ahead of the invert
  always_ff @(posedge config_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= io.data_in;
      sync2_q <= sync1_q;
    end
  end

  assign din_src = sync2_q;
`else
  assign din_src = io.data_in;
`endif

  // ---------------------------------------------------------------------
  // Datapaths
  // ---------------------------------------------------------------------

  // Invert applied before the optional register, so in_q/out_q hold already-inverted data
  always_comb begin
    a_vec = din_src ^ inv;
    b_vec = io.cx_io ^ inv;
    in_d  = a_vec;
    out_d = b_vec;
  end

  // Data flops run every cycle, including during shifting; they are only cleared by reset
  always_ff @(posedge config_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      in_q  <= '0;
      out_q <= '0;
    end else begin
      in_q  <= in_d;
      out_q <= out_d;
    end
  end

  // Per-cell path select plus the global safe-state gate (unconfigured or mid-shift)
  always_comb begin
    gate     = done_q & ~io.config_en;
    in_path  = (reg_sel & in_q)  | (~reg_sel & a_vec);
    out_path = (reg_sel & out_q) | (~reg_sel & b_vec);
  end

  assign io.io_cx    = {WIDTH{gate}} & in_en  & in_path;
  assign io.data_out = {WIDTH{gate}} & out_en & out_path;
  assign io.data_oe  = {WIDTH{gate}} & out_en;

endmodule

// File: tb/tb_io_block_reg.sv
// tb_io_block_reg: randomized and directed checks of io_block_reg (WIDTH=4) against a behavioural model.
// Latency: model tracks 0/1-cycle paths (2/3 with IO_BLOCK_SYNC_EN) and serial chain timing.
// Backpressure: none; inputs driven on the falling edge, outputs sampled 1ns later.
`timescale 1ns/1ps
module tb_io_block_reg;

  localparam int W = 4;
  localparam int N = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  io_block_reg_if #(.WIDTH(W)) bus ();

  io_block_reg #(.WIDTH(W), .CFG_BITS(4)) dut (
    .config_clk (clk),
    .sys_reset  (rst_n),
    .io         (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [N-1:0] m_cfg;
  int           m_cnt;
  logic [W-1:0] m_inq, m_outq, m_s1, m_s2;

  // snapshot of the outputs taken at the last check point
  logic [W-1:0] snap_cx, snap_do, snap_oe;
  logic         snap_cout, snap_done;

  // bit b of every cell's 4-bit field, taken arithmetically from the model word
  function automatic logic [W-1:0] fld(input int b);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = 1'((m_cfg >> (4*i + b)) & 1);
    return r;
  endfunction

  function automatic logic [W-1:0] model_a();
`ifdef IO_BLOCK_SYNC_EN
    return m_s2 ^ fld(3);
`else
    return bus.data_in ^ fld(3);
`endif
  endfunction

  task automatic model_reset();
    m_cfg = '0; m_cnt = 0;
    m_inq = '0; m_outq = '0; m_s1 = '0; m_s2 = '0;
  endtask

  task automatic model_clock();
    m_inq  = model_a();
    m_outq = bus.cx_io ^ fld(3);
    m_s2   = m_s1;
    m_s1   = bus.data_in;
    if (bus.config_en) begin
      m_cfg = {m_cfg[N-2:0], bus.config_in};
      if (m_cnt < N) m_cnt++;
    end
  endtask

  task automatic check_outs();
    logic         g;
    logic [W-1:0] ien, oen, rg, a, b, e_cx, e_do, e_oe;
    g   = (m_cnt == N) && !bus.config_en;
    ien = fld(0); oen = fld(1); rg = fld(2);
    a   = model_a();
    b   = bus.cx_io ^ fld(3);
    for (int i = 0; i < W; i++) begin
      e_cx[i] = g & ien[i] & (rg[i] ? m_inq[i]  : a[i]);
      e_do[i] = g & oen[i] & (rg[i] ? m_outq[i] : b[i]);
      e_oe[i] = g & oen[i];
    end
    chk("io_cx",       bus.io_cx,       e_cx);
    chk("data_out",    bus.data_out,    e_do);
    chk("data_oe",     bus.data_oe,     e_oe);
    chk("config_out",  bus.config_out,  m_cfg[N-1]);
    chk("config_done", bus.config_done, m_cnt == N);
    snap_cx = bus.io_cx; snap_do = bus.data_out; snap_oe = bus.data_oe;
    snap_cout = bus.config_out; snap_done = bus.config_done;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cycle(input logic cin, input logic cen, input logic [W-1:0] din, input logic [W-1:0] cx);
    @(negedge clk);
    bus.config_in = cin; bus.config_en = cen; bus.data_in = din; bus.cx_io = cx;
    #1 check_outs();
    @(posedge clk);
    if (rst_n) model_clock();
  endtask

  task automatic rand_cycle(input logic cen);
    cycle(1'($urandom), cen, W'($urandom), W'($urandom));
  endtask

  task automatic shift_word(input logic [N-1:0] w);
    for (int k = N - 1; k >= 0; k--) cycle(w[k], 1'b1, W'($urandom), W'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.config_en = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1 check_outs();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] cap, w;
    bus.config_in = 1'b0; bus.config_en = 1'b0;
    bus.data_in = '0; bus.cx_io = '0;
    model_reset();

    // 1: reset state, 15 bits not enough, 16th raises done
    do_reset();
    chk("t1_rst_done", bus.config_done, 1'b0);
    for (int k = 0; k < N - 1; k++) rand_cycle(1'b1);
    cycle(1'b0, 1'b0, 4'hF, 4'hF);
    chk("t1_done15", snap_done, 1'b0);
    chk("t1_outs15", {snap_cx, snap_do, snap_oe}, 12'h000);
    rand_cycle(1'b1);
    rand_cycle(1'b0);
    chk("t1_done16", snap_done, 1'b1);

    // 2: cell0 input enable, unregistered
    shift_word(16'h0001);
`ifdef IO_BLOCK_SYNC_EN
    repeat (3) cycle(1'b0, 1'b0, 4'b0000, 4'h0);
    cycle(1'b0, 1'b0, 4'b0001, 4'h0);
    chk("t6_sync_lat0", snap_cx[0], 1'b0);
    cycle(1'b0, 1'b0, 4'b0001, 4'h0);
    chk("t6_sync_lat1", snap_cx[0], 1'b0);
    cycle(1'b0, 1'b0, 4'b0001, 4'h0);
    chk("t6_sync_lat2", snap_cx[0], 1'b1);
`else
    cycle(1'b0, 1'b0, 4'b0001, W'($urandom));
    chk("t2_io_cx", snap_cx, 4'b0001);
    chk("t2_oe", snap_oe, 4'b0000);
`endif

    // 3: cell1 out_en+reg+inv, cx_io[1]=0 appears inverted one cycle later
    shift_word(16'h00E0);
    cycle(1'b0, 1'b0, 4'h0, 4'h0);
    cycle(1'b0, 1'b0, 4'h0, 4'h0);
    chk("t3_data_out1", snap_do[1], 1'b1);
    chk("t3_oe", snap_oe, 4'b0010);

    // 4: pattern emerges from config_out MSB first
    shift_word(16'hA5C3);
    cap = '0;
    for (int k = 0; k < N; k++) begin
      rand_cycle(1'b1);
      cap = {cap[N-2:0], snap_cout};
    end
    chk("t4_chain", cap, 16'hA5C3);

    // 5: single-cycle config_en pulse while running
    w = N'($urandom) | 16'h3333;
    shift_word(w);
    repeat (5) rand_cycle(1'b0);
    rand_cycle(1'b1);
    chk("t5_forced", {snap_cx, snap_do, snap_oe}, 12'h000);
    rand_cycle(1'b0);
    chk("t5_shifted", snap_cout, w[N-2]);

    // 6: reset in the middle of a reconfiguration clears everything at once
    shift_word(16'h3333);
    for (int k = 0; k < 8; k++) rand_cycle(1'b1);
    @(negedge clk);
    bus.config_en = 1'b0; bus.data_in = 4'hF; bus.cx_io = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_done_async", bus.config_done, 1'b0);
    chk("t6_outs_async", {bus.io_cx, bus.data_out, bus.data_oe}, 12'h000);
    chk("t6_cout_async", bus.config_out, 1'b0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) rand_cycle(1'b1);
    rand_cycle(1'b0);
    chk("t6_restart_done", snap_done, 1'b0);

    // randomized operation: reconfigs, config_en pulses, occasional resets
    for (int k = 0; k < 2500; k++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        do_reset();
      end else if (r < 15) begin
        shift_word(N'($urandom));
      end else begin
        rand_cycle($urandom_range(0, 19) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
